adder16_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one instance of the team's 16-bit ripple-carry adder (`adder16bit`) among `NREQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the captured operands into the adder. It registers the sum and the five status flags, and returns them with the requester ID over a valid/ready response channel. It sits between the client datapaths and the shared adder and is the only block that drives the adder's inputs.

---
 rtl/adder16_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_adder16_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder16_arbiter.sv
// rtl/adder16_arbiter.sv - round-robin arbiter sequencing requesters onto one shared 16-bit adder
//
// adder16bit: 16-bit ripple-carry adder with status flags.
//   x, y   : operands
//   z      : x + y mod 2^16
//   flags  : {overflow, parity, carry, zero, sign}
//
// adder16_arbiter: accepts one operand pair at a time from NREQ requesters
// (round-robin), runs it through adder16bit and returns the registered result.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid[NREQ]       : requester i presents operands
//   req_ready[NREQ]       : one-hot accept strobe, only in IDLE
//   req_x/req_y[16*NREQ]  : operands, requester i at [16i+15:16i]
//   rsp_valid, rsp_ready  : response handshake
//   rsp_id, rsp_z         : owner of the result, registered sum
//   rsp_flags             : registered {overflow, parity, carry, zero, sign}
//   op_count              : completed responses, wraps at 2^16

module adder16bit (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] z,
    output logic [4:0]  flags
);
    logic [16:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign z[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    // Signed overflow: both operands share a sign and the sum has the other one.
    assign flags = {(x[15] == y[15]) && (z[15] != x[15]),
                    ~^z,
                    c[16],
                    z == 16'h0000,
                    z[15]};
endmodule

module adder16_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*16-1:0] req_x,
    input  logic [NREQ*16-1:0] req_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [15:0]        rsp_z,
    output logic [4:0]         rsp_flags,
    output logic [15:0]        op_count
);
    localparam int PW = IDW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  cap_id_q;
    logic [15:0]     cap_x_q;
    logic [15:0]     cap_y_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [15:0]     rsp_z_q;
    logic [4:0]      rsp_flags_q;
    logic [15:0]     op_cnt_q;

    logic            found;
    logic [IDW-1:0]  win;
    logic [PW-1:0]   idx_w;
    logic [NREQ-1:0] grant;
    logic [15:0]     sel_x;
    logic [15:0]     sel_y;
    logic [15:0]     sum;
    logic [4:0]      sum_flags;
    logic [PW-1:0]   nxt_w;
    logic [IDW-1:0]  rr_next;
    logic            rsp_fire;

    // Winner search: first set request at or after rr_ptr, wrapping at NREQ.
    // The extra index bit keeps the wrap correct for non-power-of-two NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_w = {1'b0, rr_ptr_q} + PW'(i);
            if (idx_w >= PW'(NREQ)) begin
                idx_w = idx_w - PW'(NREQ);
            end
            if (!found && req_valid[idx_w[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx_w[IDW-1:0];
            end
        end
    end

    assign grant = found ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;

    // Operand lane of the winner, captured on the accept edge.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                sel_x = req_x[16*i +: 16];
                sel_y = req_y[16*i +: 16];
            end
        end
    end

    // Pointer moves just past the requester whose response completes.
    always_comb begin
        nxt_w = {1'b0, rsp_id_q} + PW'(1);
        if (nxt_w >= PW'(NREQ)) begin
            nxt_w = '0;
        end
        rr_next = nxt_w[IDW-1:0];
    end

    assign rsp_fire = rsp_valid_q && rsp_ready;

    // The adder only ever sees the captured operands, never live inputs.
    adder16bit u_adder (
        .x     (cap_x_q),
        .y     (cap_y_q),
        .z     (sum),
        .flags (sum_flags)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)    state_d = CALC;
            CALC:                  state_d = RESP;
            RESP:    if (rsp_fire) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Accept strobe is combinational and squashed while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE)) begin
            req_ready = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cap_id_q    <= '0;
            cap_x_q     <= '0;
            cap_y_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
            rsp_flags_q <= '0;
            op_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        cap_id_q <= win;
                        cap_x_q  <= sel_x;
                        cap_y_q  <= sel_y;
                    end
                end
                CALC: begin
                    rsp_z_q     <= sum;
                    rsp_flags_q <= sum_flags;
                    rsp_id_q    <= cap_id_q;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_fire) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= rr_next;
                        op_cnt_q    <= op_cnt_q + 16'd1;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_flags = rsp_flags_q;
    assign op_count  = op_cnt_q;
endmodule

// File: tb/tb_adder16_arbiter.sv
// tb/tb_adder16_arbiter.sv - scoreboard bench for adder16_arbiter
module tb_adder16_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_x = '0;
    logic [63:0] req_y = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_z;
    logic [4:0]  rsp_flags;
    logic [15:0] op_count;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] z;
        logic [4:0]  f;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_ptr = 0;
    logic [15:0] exp_cnt = '0;

    adder16_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_flags (rsp_flags),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input int id, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        exp_t        e;
        s    = {1'b0, a} + {1'b0, b};
        e.id = id[1:0];
        e.z  = s[15:0];
        e.f  = {(a[15] == b[15]) && (s[15] != a[15]), ~^s[15:0], s[16], s[15:0] == 16'h0, s[15]};
        return e;
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        int j;
        for (int k = 0; k < 4; k++) begin
            j = (p + k) % 4;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    function automatic logic [15:0] lane(input logic [63:0] v, input int i);
        return v[16*i +: 16];
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < 4; i++) begin
            req_x[16*i +: 16] = 16'($urandom);
            req_y[16*i +: 16] = 16'($urandom);
        end
    endtask

    task automatic wait_grant(output logic [3:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                g  = req_ready;
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_z !== 16'h0) begin errors++; $display("FAIL reset_rsp_z got %h exp 0000", rsp_z); end
        checks++; if (rsp_flags !== 5'h0) begin errors++; $display("FAIL reset_rsp_flags got %b exp 00000", rsp_flags); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count got %h exp 0000", op_count); end
        req_valid = 4'h0;
        rst_n = 1'b1;
        exp_ptr = 0;
        exp_cnt = '0;
        @(negedge clk);
    endtask

    task automatic test_single();
        exp_t e;
        @(negedge clk);
        req_x[32 +: 16] = 16'h7FFF;
        req_y[32 +: 16] = 16'h0001;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready); end
        sbq.push_back(model(pick(req_valid, exp_ptr), 16'h7FFF, 16'h0001));
        @(negedge clk);
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early got %b exp 0", rsp_valid); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
            errors++; $display("FAIL single_rsp_valid got %b exp 1", rsp_valid);
        end else begin
            e = sbq.pop_front();
            checks++;
            if ({rsp_id, rsp_z, rsp_flags} !== {e.id, e.z, e.f}) begin
                errors++; $display("FAIL single_rsp got id=%0d z=%h f=%b exp id=%0d z=%h f=%b", rsp_id, rsp_z, rsp_flags, e.id, e.z, e.f);
            end
        end
        exp_ptr = 3;
        exp_cnt++;
        @(negedge clk);
        checks++; if (op_count !== exp_cnt || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_count got %h/%b exp %h/0", op_count, rsp_valid, exp_cnt); end
    endtask

    task automatic test_flags();
        logic [15:0] xs[2];
        logic [15:0] ys[2];
        logic [3:0]  g;
        bit          ok;
        exp_t        e;
        xs[0] = 16'hFFFF; ys[0] = 16'h0001;
        xs[1] = 16'h8000; ys[1] = 16'h8000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_x[15:0] = xs[k];
            req_y[15:0] = ys[k];
            req_valid = 4'b0001;
            wait_grant(g, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL flags_grant_timeout got %b exp 0001", g); end
            else if (g !== 4'b0001) begin errors++; $display("FAIL flags_grant got %b exp 0001", g); end
            sbq.push_back(model(0, xs[k], ys[k]));
            @(negedge clk);
            req_valid = 4'b0000;
            wait_rsp(ok);
            checks++;
            if (!ok || sbq.size() == 0) begin
                errors++; $display("FAIL flags_rsp_timeout got %b exp 1", rsp_valid);
                sbq.delete();
            end else begin
                e = sbq.pop_front();
                if ({rsp_id, rsp_z, rsp_flags} !== {e.id, e.z, e.f}) begin
                    errors++; $display("FAIL flags_rsp got id=%0d z=%h f=%b exp id=%0d z=%h f=%b", rsp_id, rsp_z, rsp_flags, e.id, e.z, e.f);
                end
            end
            exp_ptr = 1;
            exp_cnt++;
            @(negedge clk);
            checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL flags_count got %h exp %h", op_count, exp_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        int         w;
        logic [3:0] oh;
        exp_t       e;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 0;
        exp_cnt = '0;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int op = 0; op < 12; op++) begin
            randomize_ops();
            #1;
            w  = pick(req_valid, exp_ptr);
            oh = 4'b0001 << w;
            checks++; if (req_ready !== oh) begin errors++; $display("FAIL rr_grant op%0d got %b exp %b", op, req_ready, oh); end
            sbq.push_back(model(w, lane(req_x, w), lane(req_y, w)));
            @(negedge clk);
            randomize_ops();
            #1;
            checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_calc op%0d got ready=%b valid=%b exp 0000/0", op, req_ready, rsp_valid); end
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 4'b0000 || sbq.size() == 0) begin
                errors++; $display("FAIL rr_resp op%0d got valid=%b ready=%b exp 1/0000", op, rsp_valid, req_ready);
                sbq.delete();
            end else begin
                e = sbq.pop_front();
                if ({rsp_id, rsp_z, rsp_flags} !== {e.id, e.z, e.f}) begin
                    errors++; $display("FAIL rr_rsp op%0d got id=%0d z=%h f=%b exp id=%0d z=%h f=%b", op, rsp_id, rsp_z, rsp_flags, e.id, e.z, e.f);
                end
            end
            exp_ptr = (w + 1) % 4;
            exp_cnt++;
            @(negedge clk);
        end
        req_valid = 4'h0;
        checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL rr_count got %h exp %h", op_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        int         w;
        logic [3:0] oh;
        exp_t       e;
        bit         ok;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        randomize_ops();
        #1;
        w  = pick(req_valid, exp_ptr);
        oh = 4'b0001 << w;
        checks++; if (req_ready !== oh) begin errors++; $display("FAIL bp_grant got %b exp %b", req_ready, oh); end
        e = model(w, lane(req_x, w), lane(req_y, w));
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            randomize_ops();
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_z, rsp_flags} !== {1'b1, e.id, e.z, e.f} || req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_hold c%0d got v=%b id=%0d z=%h f=%b rdy=%b exp v=1 id=%0d z=%h f=%b rdy=0000",
                                   c, rsp_valid, rsp_id, rsp_z, rsp_flags, req_ready, e.id, e.z, e.f);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_release_ready got %b exp 0000", req_ready); end
        @(negedge clk);
        exp_cnt++;
        exp_ptr = (w + 1) % 4;
        #1;
        checks++; if (op_count !== exp_cnt || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_complete got %h/%b exp %h/0", op_count, rsp_valid, exp_cnt); end
        w  = pick(req_valid, exp_ptr);
        oh = 4'b0001 << w;
        checks++; if (req_ready !== oh) begin errors++; $display("FAIL bp_next_grant got %b exp %b", req_ready, oh); end
        sbq.push_back(model(w, lane(req_x, w), lane(req_y, w)));
        @(negedge clk);
        req_valid = 4'h0;
        wait_rsp(ok);
        checks++;
        if (!ok || sbq.size() == 0) begin
            errors++; $display("FAIL bp_next_rsp_timeout got %b exp 1", rsp_valid);
            sbq.delete();
        end else begin
            e = sbq.pop_front();
            if ({rsp_id, rsp_z, rsp_flags} !== {e.id, e.z, e.f}) begin
                errors++; $display("FAIL bp_next_rsp got id=%0d z=%h f=%b exp id=%0d z=%h f=%b", rsp_id, rsp_z, rsp_flags, e.id, e.z, e.f);
            end
        end
        exp_cnt++;
        exp_ptr = (w + 1) % 4;
        @(negedge clk);
        checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL bp_next_count got %h exp %h", op_count, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] oh;
        @(negedge clk);
        req_valid = 4'b0010;
        randomize_ops();
        #1;
        oh = 4'b0001 << pick(req_valid, exp_ptr);
        checks++; if (req_ready !== oh) begin errors++; $display("FAIL abort_grant got %b exp %b", req_ready, oh); end
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL abort_ready_in_reset got %b exp 0000", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 0;
        exp_cnt = '0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || op_count !== 16'h0) begin errors++; $display("FAIL abort_state got %b/%h exp 0/0000", rsp_valid, op_count); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_idle_ptr got %b exp 0001", req_ready); end
        req_valid = 4'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rsp c%0d got %b exp 0", c, rsp_valid); end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] oh;
        exp_t       e;
        bit         ok;
        @(negedge clk);
        force dut.op_cnt_q = 16'hFFFF;
        #1;
        release dut.op_cnt_q;
        exp_cnt = 16'hFFFF;
        #1;
        checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL wrap_preload got %h exp %h", op_count, exp_cnt); end
        @(negedge clk);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        randomize_ops();
        #1;
        oh = 4'b0001 << pick(req_valid, exp_ptr);
        checks++; if (req_ready !== oh) begin errors++; $display("FAIL wrap_grant got %b exp %b", req_ready, oh); end
        sbq.push_back(model(3, lane(req_x, 3), lane(req_y, 3)));
        @(negedge clk);
        req_valid = 4'h0;
        wait_rsp(ok);
        checks++;
        if (!ok || sbq.size() == 0) begin
            errors++; $display("FAIL wrap_rsp_timeout got %b exp 1", rsp_valid);
            sbq.delete();
        end else begin
            e = sbq.pop_front();
            if ({rsp_id, rsp_z, rsp_flags} !== {e.id, e.z, e.f}) begin
                errors++; $display("FAIL wrap_rsp got id=%0d z=%h f=%b exp id=%0d z=%h f=%b", rsp_id, rsp_z, rsp_flags, e.id, e.z, e.f);
            end
        end
        exp_cnt++;
        @(negedge clk);
        checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL wrap_count got %h exp %h", op_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_flags();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        checks++; if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", sbq.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
